blinker_pio: RTL and testbench

BLINKER_PIO -- requirements
Module: blinker_pio

---
 rtl/blinker_pio_pkg.sv | 19 +
 rtl/blinker_prescaler.sv | 48 ++++
 rtl/blinker_pio.sv | 131 +++++++++++++
 tb/tb_blinker_pio.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blinker_pio_pkg.sv
// Shared constants for the blinking LED parallel output port: the register
// word addresses on the Avalon-MM slave and the bit positions inside STATUS
// and IRQ_MASK.
package blinker_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_SET      = 3'd4;
    localparam logic [2:0] ADDR_CLEAR    = 3'd5;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;
    localparam logic [2:0] ADDR_RESERVED = 3'd7;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_WRAP_BIT  = 1;
    localparam int IRQ_MASK_BIT     = 0;

endpackage

// File: rtl/blinker_prescaler.sv
// Blink timebase: counts clk cycles up to the programmed period and flips the
// blink phase each time the count wraps. The wrap output is a one-cycle
// indication that the coming edge is a wrap edge, so the parent can latch a
// sticky flag on exactly the same edge the phase toggles.
module blinker_prescaler
    import blinker_pio_pkg::*;
#(
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] period,
    input  logic                 restart,
    output logic                 phase,
    output logic                 wrap
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_phase;
    logic                 w_terminal;

    // A greater-or-equal compare keeps the counter from ever running past a
    // freshly lowered period, even though a period write also restarts it.
    assign w_terminal = (r_cnt >= period);
    assign wrap       = enable & ~restart & w_terminal;
    assign phase      = r_phase;

    // Counter and phase: idle at (0, on) while disabled, restart without a
    // phase flip on a period change, otherwise count and toggle on wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (!enable) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (restart) begin
            r_cnt   <= '0;
        end else if (w_terminal) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/blinker_pio.sv
// Avalon-MM LED output port with per-bit blinking. DATA selects which LEDs
// are lit, BLINK_EN selects which of those follow the blink phase, PERIOD sets
// the half-period of the blink, and a sticky wrap flag can raise a level irq.
module blinker_pio
    import blinker_pio_pkg::*;
#(
    parameter int                   WIDTH        = 8,
    parameter int                   DIV_WIDTH    = 24,
    parameter logic [WIDTH-1:0]     RESET_VALUE  = '0,
    parameter logic [DIV_WIDTH-1:0] PERIOD_RESET = {DIV_WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic [WIDTH-1:0]     r_data;
    logic [WIDTH-1:0]     r_blinkEn;
    logic [DIV_WIDTH-1:0] r_period;
    logic                 r_irqMask;
    logic                 r_wrap;

    logic                 w_write;
    logic                 w_wrData;
    logic                 w_wrBlinkEn;
    logic                 w_wrPeriod;
    logic                 w_wrStatus;
    logic                 w_wrSet;
    logic                 w_wrClear;
    logic                 w_wrIrqMask;
    logic                 w_enable;
    logic                 w_phase;
    logic                 w_wrapPulse;
    logic                 w_unusedWritedata;

    assign w_write     = chipselect & ~write_n;
    assign w_wrData    = w_write && (address == ADDR_DATA);
    assign w_wrBlinkEn = w_write && (address == ADDR_BLINK_EN);
    assign w_wrPeriod  = w_write && (address == ADDR_PERIOD);
    assign w_wrStatus  = w_write && (address == ADDR_STATUS);
    assign w_wrSet     = w_write && (address == ADDR_SET);
    assign w_wrClear   = w_write && (address == ADDR_CLEAR);
    assign w_wrIrqMask = w_write && (address == ADDR_IRQ_MASK);

    // Bits of writedata beyond the register widths are deliberately ignored.
    assign w_unusedWritedata = &{1'b0, writedata};

    assign w_enable = |r_blinkEn;

    blinker_prescaler #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (w_enable),
        .period  (r_period),
        .restart (w_wrPeriod),
        .phase   (w_phase),
        .wrap    (w_wrapPulse)
    );

    // DATA register: direct write, or bitwise set/clear via the strobe addresses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
        end else if (w_wrData) begin
            r_data <= writedata[WIDTH-1:0];
        end else if (w_wrSet) begin
            r_data <= r_data | writedata[WIDTH-1:0];
        end else if (w_wrClear) begin
            r_data <= r_data & ~writedata[WIDTH-1:0];
        end
    end

    // Blink enable mask, blink period and interrupt mask registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blinkEn <= '0;
            r_period  <= PERIOD_RESET;
            r_irqMask <= 1'b0;
        end else begin
            if (w_wrBlinkEn) begin
                r_blinkEn <= writedata[WIDTH-1:0];
            end
            if (w_wrPeriod) begin
                r_period <= writedata[DIV_WIDTH-1:0];
            end
            if (w_wrIrqMask) begin
                r_irqMask <= writedata[IRQ_MASK_BIT];
            end
        end
    end

    // Sticky wrap flag: a wrap on the same edge beats a write-one-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrap <= 1'b0;
        end else if (w_wrapPulse) begin
            r_wrap <= 1'b1;
        end else if (w_wrStatus && writedata[STATUS_WRAP_BIT]) begin
            r_wrap <= 1'b0;
        end
    end

    // Zero-wait-state read mux, zero-extended; write-only and reserved read 0.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]     = r_data;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]     = r_blinkEn;
            ADDR_PERIOD:   readdata[DIV_WIDTH-1:0] = r_period;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT] = w_phase;
                readdata[STATUS_WRAP_BIT]  = r_wrap;
            end
            ADDR_IRQ_MASK: readdata[IRQ_MASK_BIT]  = r_irqMask;
            default:       readdata                = '0;
        endcase
    end

    // LED drive and interrupt come straight from registers only.
    assign out_port = r_data & (~r_blinkEn | {WIDTH{w_phase}});
    assign irq      = r_wrap & r_irqMask;

endmodule

// File: tb/tb_blinker_pio.sv
// Self-checking bench for blinker_pio with WIDTH=8, DIV_WIDTH=4. A register
// level model tracks the blink timebase as "cycles elapsed since the last
// restart" and derives phase and wrap events from that count arithmetically.
module tb_blinker_pio;

    localparam int         W   = 8;
    localparam int         DW  = 4;
    localparam logic [7:0] RV  = 8'h5A;

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_BLINK  = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_STATUS = 3'd3;
    localparam logic [2:0] A_SET    = 3'd4;
    localparam logic [2:0] A_CLEAR  = 3'd5;
    localparam logic [2:0] A_MASK   = 3'd6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state
    logic [7:0] mData;
    logic [7:0] mBlinkEn;
    logic [3:0] mPeriod;
    bit         mMask;
    bit         mWrap;
    bit         mPhaseStart;
    int         mElapsed;

    blinker_pio #(
        .WIDTH        (W),
        .DIV_WIDTH    (DW),
        .RESET_VALUE  (RV),
        .PERIOD_RESET (4'hF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit modelPhase();
        int halves;
        halves = mElapsed / (int'(mPeriod) + 1);
        return mPhaseStart ^ halves[0];
    endfunction

    function automatic logic [7:0] modelOut();
        return mData & (~mBlinkEn | {8{modelPhase()}});
    endfunction

    function automatic logic [31:0] modelRead(input logic [2:0] a);
        case (a)
            A_DATA:   return {24'h0, mData};
            A_BLINK:  return {24'h0, mBlinkEn};
            A_PERIOD: return {28'h0, mPeriod};
            A_STATUS: return {30'h0, mWrap, modelPhase()};
            A_MASK:   return {31'h0, mMask};
            default:  return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        mData       = RV;
        mBlinkEn    = '0;
        mPeriod     = 4'hF;
        mMask       = 1'b0;
        mWrap       = 1'b0;
        mPhaseStart = 1'b1;
        mElapsed    = 0;
    endtask

    // Predict register state after one rising edge with the given bus action.
    task automatic modelEdge(input bit wr, input logic [2:0] a, input logic [31:0] d);
        bit wrapEvt;
        wrapEvt = 1'b0;
        if (mBlinkEn != 0) begin
            if (wr && a == A_PERIOD) begin
                mPhaseStart = modelPhase();
                mElapsed    = 0;
            end else begin
                mElapsed++;
                if (mElapsed % (int'(mPeriod) + 1) == 0) wrapEvt = 1'b1;
            end
        end else begin
            mElapsed    = 0;
            mPhaseStart = 1'b1;
        end
        if (wr) begin
            case (a)
                A_DATA:   mData    = d[7:0];
                A_BLINK:  mBlinkEn = d[7:0];
                A_PERIOD: mPeriod  = d[3:0];
                A_SET:    mData    = mData | d[7:0];
                A_CLEAR:  mData    = mData & ~d[7:0];
                A_MASK:   mMask    = d[0];
                default:  ;
            endcase
        end
        if (wrapEvt) mWrap = 1'b1;
        else if (wr && a == A_STATUS && d[1]) mWrap = 1'b0;
    endtask

    // One bus cycle, driven in the low clock phase and checked on the next one.
    task automatic applyStimulus(input bit wr, input logic [2:0] a, input logic [31:0] d);
        if (wr) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else if ($urandom_range(1, 0) == 1) begin
            chipselect = 1'b0;
            write_n    = 1'($urandom_range(1, 0));
        end else begin
            chipselect = 1'b1;
            write_n    = 1'b1;
        end
        address   = a;
        writedata = d;
        modelEdge(wr, a, d);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);
        checkOutput("out_port", 32'(out_port), 32'(modelOut()));
        checkOutput("irq", 32'(irq), 32'(mWrap & mMask));
    endtask

    task automatic checkRead(input string tag, input logic [2:0] a);
        address = a;
        #1;
        checkOutput(tag, readdata, modelRead(a));
    endtask

    task automatic asyncReset();
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_out_port", 32'(out_port), 32'(RV));
        checkOutput("rst_irq", 32'(irq), 32'h0);
        address = A_STATUS;
        #1;
        checkOutput("rst_status", readdata, 32'h1);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [2:0]  a;
        logic [31:0] d;
        bit          wr;

        $display("[TB] blinker_pio test starting");
        modelReset();
        @(negedge clk);
        @(negedge clk);

        // Reset state with no writes
        checkOutput("reset_out_port", 32'(out_port), 32'(RV));
        checkOutput("reset_irq", 32'(irq), 32'h0);
        address = A_DATA;   #1; checkOutput("reset_rd_data", readdata, 32'h5A);
        address = A_BLINK;  #1; checkOutput("reset_rd_blink", readdata, 32'h0);
        address = A_STATUS; #1; checkOutput("reset_rd_status", readdata, 32'h1);
        address = A_MASK;   #1; checkOutput("reset_rd_mask", readdata, 32'h0);
        reset_n = 1'b1;
        applyStimulus(0, A_DATA, 32'h0);
        applyStimulus(0, A_DATA, 32'h0);

        // DATA, SET, CLEAR with junk in the upper writedata bits
        applyStimulus(1, A_DATA, 32'hC0DE_00A5);
        address = A_DATA; #1; checkOutput("data_write", readdata, 32'hA5);
        checkOutput("data_out", 32'(out_port), 32'hA5);
        applyStimulus(1, A_SET, 32'hDEAD_BE0F);
        address = A_DATA; #1; checkOutput("data_set", readdata, 32'hAF);
        checkOutput("set_out", 32'(out_port), 32'hAF);
        applyStimulus(1, A_CLEAR, 32'h1234_5681);
        address = A_DATA; #1; checkOutput("data_clear", readdata, 32'h2E);
        checkOutput("clear_out", 32'(out_port), 32'h2E);

        // Blinking with PERIOD=3 and irq enabled
        applyStimulus(1, A_MASK, 32'h1);
        applyStimulus(1, A_DATA, 32'hFF);
        applyStimulus(1, A_PERIOD, 32'h3);
        applyStimulus(1, A_BLINK, 32'h0F);
        checkOutput("blink_k0", 32'(out_port), 32'hFF);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(0, A_DATA, 32'h0);
            checkOutput($sformatf("blink_k%0d", k), 32'(out_port), (k >= 4) ? 32'hF0 : 32'hFF);
            address = A_STATUS; #1;
            checkOutput($sformatf("wrap_k%0d", k), 32'(readdata[1]), (k >= 4) ? 32'h1 : 32'h0);
        end
        checkOutput("irq_first_wrap", 32'(irq), 32'h1);

        // Write-one-to-clear on a quiet edge, then on a wrap edge
        applyStimulus(1, A_STATUS, 32'h2);
        checkOutput("w1c_quiet_irq", 32'(irq), 32'h0);
        applyStimulus(1, A_STATUS, 32'h2);
        checkOutput("w1c_wrap_irq", 32'(irq), 32'h1);
        checkOutput("wrap_edge_out", 32'(out_port), 32'hFF);

        // Lowering PERIOD mid-count restarts without an extra toggle
        applyStimulus(1, A_STATUS, 32'h2);
        applyStimulus(0, A_DATA, 32'h0);
        applyStimulus(1, A_PERIOD, 32'h1);
        checkOutput("per_w_out", 32'(out_port), 32'hFF);
        checkOutput("per_w_irq", 32'(irq), 32'h0);
        applyStimulus(0, A_DATA, 32'h0);
        checkOutput("per_1_out", 32'(out_port), 32'hFF);
        checkOutput("per_1_irq", 32'(irq), 32'h0);
        applyStimulus(0, A_DATA, 32'h0);
        checkOutput("per_2_out", 32'(out_port), 32'hF0);
        checkOutput("per_2_irq", 32'(irq), 32'h1);

        // Asynchronous reset in the dark half of the blink
        applyStimulus(0, A_DATA, 32'h0);
        checkOutput("pre_rst_out", 32'(out_port), 32'hF0);
        asyncReset();

        // Randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(399, 0) == 0) asyncReset();
            if ($urandom_range(2, 0) == 0) checkRead("rand_read", 3'($urandom_range(7, 0)));
            wr = ($urandom_range(3, 0) == 0);
            a  = 3'($urandom_range(7, 0));
            d  = $urandom;
            if (a == A_PERIOD && $urandom_range(3, 0) != 0) d[3:0] = 4'($urandom_range(3, 0));
            if (a == A_BLINK && $urandom_range(3, 0) == 0) d = 32'h0;
            if (a == A_STATUS && $urandom_range(1, 0) == 0) d[1] = 1'b1;
            applyStimulus(wr, a, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
